// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// pe_pkg : shared defaults and constant helpers for the accumulation tree
// rev 1.0
// ============================================================================
package pe_pkg;

    localparam int N_IN_DEF    = 16;
    localparam int GROUP_DEF   = 4;
    localparam int IN_W_DEF    = 6;
    localparam int SHIFT_W_DEF = 3;
    localparam int ACC_W_DEF   = 24;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_add_group.sv
`default_nettype none
// ============================================================================
// pe_add_group : combinational signed adder of GROUP lanes, sign-extended out
// rev 1.0
// ============================================================================
module pe_add_group
    import pe_pkg::*;
#(
    parameter int GROUP = GROUP_DEF,
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = IN_W_DEF + clog2(GROUP_DEF)
) (
    input  logic [GROUP*IN_W-1:0] in_p,
    output logic [OUT_W-1:0]      sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < GROUP; i++) begin
            sum = sum + OUT_W'(signed'(in_p[i*IN_W +: IN_W]));
        end
    end

endmodule
`default_nettype wire

// File: rtl/pe_acc_tree.sv
`default_nettype none
// ============================================================================
// pe_acc_tree : pipelined signed adder tree with shift-weighted accumulator
// rev 1.0
// ============================================================================
module pe_acc_tree
    import pe_pkg::*;
#(
    parameter int N_IN    = N_IN_DEF,
    parameter int GROUP   = GROUP_DEF,
    parameter int IN_W    = IN_W_DEF,
    parameter int SHIFT_W = SHIFT_W_DEF,
    parameter int ACC_W   = ACC_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*IN_W-1:0]   in_p,
    input  logic [SHIFT_W-1:0]     in_shift,
    input  logic                   in_first,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_sum,
    output logic                   out_ovf
);

    localparam int N_G = N_IN / GROUP;
    localparam int GW  = IN_W + clog2(GROUP);
    localparam int TW  = IN_W + clog2(N_IN);
    localparam int SW  = TW + (1 << SHIFT_W) - 1;

    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    logic [GW-1:0] grp_sum [N_G];

    generate
        for (genvar g = 0; g < N_G; g++) begin : g_grp
            pe_add_group #(
                .GROUP (GROUP),
                .IN_W  (IN_W),
                .OUT_W (GW)
            ) u_add (
                .in_p (in_p[g*GROUP*IN_W +: GROUP*IN_W]),
                .sum  (grp_sum[g])
            );
        end
    endgenerate

    // S1: group sums
    logic               s1_valid, s1_first, s1_last;
    logic [SHIFT_W-1:0] s1_shift;
    logic [GW-1:0]      s1_grp [N_G];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_shift <= '0;
            for (int g = 0; g < N_G; g++) s1_grp[g] <= '0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            s1_first <= in_first;
            s1_last  <= in_last;
            s1_shift <= in_shift;
            for (int g = 0; g < N_G; g++) s1_grp[g] <= grp_sum[g];
        end
    end

    logic signed [TW-1:0] tree_sum;

    always_comb begin
        tree_sum = '0;
        for (int g = 0; g < N_G; g++) begin
            tree_sum = tree_sum + TW'(signed'(s1_grp[g]));
        end
    end

    // S2: full tree sum, wide enough to be exact
    logic                 s2_valid, s2_first, s2_last;
    logic [SHIFT_W-1:0]   s2_shift;
    logic signed [TW-1:0] s2_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_shift <= '0;
            s2_sum   <= '0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_shift <= s1_shift;
            s2_sum   <= tree_sum;
        end
    end

    logic signed [SW-1:0]    shifted;
    logic signed [ACC_W-1:0] addend, acc_base, acc_sum, acc;
    logic                    ovf_base, add_ovf, acc_ovf;

    // The sticky flag restarts on first or once the previous result is taken.
    always_comb begin
        shifted  = SW'(s2_sum) <<< s2_shift;
        addend   = ACC_W'(shifted);
        acc_base = s2_first ? '0 : acc;
        ovf_base = (s2_first || (out_valid && out_ready)) ? 1'b0 : acc_ovf;
        acc_sum  = acc_base + addend;
        add_ovf  = (acc_base[ACC_W-1] == addend[ACC_W-1]) &&
                   (acc_sum[ACC_W-1] != acc_base[ACC_W-1]);
    end

    // S3: accumulator doubles as the result holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            acc       <= '0;
            acc_ovf   <= 1'b0;
        end else if (!stall) begin
            out_valid <= s2_valid && s2_last;
            if (s2_valid) begin
                acc     <= acc_sum;
                acc_ovf <= ovf_base || add_ovf;
            end else if (out_valid) begin
                acc_ovf <= 1'b0;
            end
        end
    end

    assign out_sum = acc;
    assign out_ovf = acc_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pe_acc_tree.sv
`default_nettype none
// ============================================================================
// tb_pe_acc_tree : directed self-checking bench for pe_acc_tree
// rev 1.0
// ============================================================================
module tb_pe_acc_tree;

    localparam int N_IN    = 16;
    localparam int IN_W    = 6;
    localparam int SHIFT_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n, in_valid, in_first, in_last, out_ready;
    logic [N_IN*IN_W-1:0] in_p;
    logic [SHIFT_W-1:0]   in_shift;
    logic                 in_ready, out_valid, out_ovf;
    logic [23:0]          out_sum;

    logic                 valid10, first10, last10, ready_o10;
    logic [N_IN*IN_W-1:0] p10;
    logic [SHIFT_W-1:0]   shift10;
    logic                 in_ready10, out_valid10, out_ovf10;
    logic [9:0]           out_sum10;

    int total = 0;
    int bad   = 0;

    pe_acc_tree dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_p(in_p), .in_shift(in_shift), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
    );

    pe_acc_tree #(.ACC_W(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(valid10), .in_ready(in_ready10),
        .in_p(p10), .in_shift(shift10), .in_first(first10), .in_last(last10),
        .out_valid(out_valid10), .out_ready(ready_o10), .out_sum(out_sum10), .out_ovf(out_ovf10)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [N_IN*IN_W-1:0] lanes(input int v);
        logic [N_IN*IN_W-1:0] r;
        logic [IN_W-1:0]      l;
        l = IN_W'(v);
        for (int k = 0; k < N_IN; k++) r[k*IN_W +: IN_W] = l;
        return r;
    endfunction

    task automatic drive(input int v, input int sh, input logic f, input logic l);
        in_valid = 1'b1;
        in_p     = lanes(v);
        in_shift = SHIFT_W'(sh);
        in_first = f;
        in_last  = l;
    endtask

    int bb_val [4] = '{5, 6, 7, -2};
    int bb_exp [4] = '{80, 96, 112, -32};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_p = '0; in_shift = '0;
        in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        valid10 = 1'b0; p10 = '0; shift10 = '0; first10 = 1'b0; last10 = 1'b0;
        ready_o10 = 1'b1;
        repeat (2) tick;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", $signed(out_sum), 0);
        chk("rst_out_ovf", out_ovf, 0);
        rst_n = 1'b1;
        tick;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_in_ready10", in_ready10, 1);

        // single sample of all -1 lanes
        drive(-1, 0, 1'b1, 1'b1);
        tick;
        in_valid = 1'b0;
        tick;
        chk("neg_latency_early", out_valid, 0);
        tick;
        chk("neg_valid", out_valid, 1);
        chk("neg_sum", $signed(out_sum), -16);
        chk("neg_ovf", out_ovf, 0);
        tick;
        chk("neg_taken", out_valid, 0);

        // shift-weighted accumulation over four samples
        for (int i = 0; i < 4; i++) begin
            drive(9, i, i == 0, i == 3);
            tick;
        end
        in_valid = 1'b0;
        tick;
        chk("shift_no_early", out_valid, 0);
        tick;
        chk("shift_valid", out_valid, 1);
        chk("shift_sum", $signed(out_sum), 2160);
        tick;
        drive(1, 0, 1'b0, 1'b1);
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        chk("cont_valid", out_valid, 1);
        chk("cont_sum", $signed(out_sum), 2176);
        tick;

        // backpressure: three results queued, fourth sample held at the input
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive(i, 0, 1'b1, 1'b1);
            tick;
        end
        drive(4, 0, 1'b1, 1'b1);
        chk("stall_valid", out_valid, 1);
        chk("stall_in_ready", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("stall_hold_ready", in_ready, 0);
            chk("stall_hold_sum", $signed(out_sum), 16);
        end
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("drain_sum_b", $signed(out_sum), 32);
        tick;
        chk("drain_sum_c", $signed(out_sum), 48);
        tick;
        chk("drain_valid_d", out_valid, 1);
        chk("drain_sum_d", $signed(out_sum), 64);
        tick;
        chk("drain_empty", out_valid, 0);

        // back-to-back single-sample results
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(bb_val[i], 0, 1'b1, 1'b1);
            else in_valid = 1'b0;
            tick;
            if (i >= 2) begin
                chk("b2b_valid", out_valid, 1);
                chk("b2b_sum", $signed(out_sum), bb_exp[i-2]);
            end
        end
        tick;
        chk("b2b_empty", out_valid, 0);

        // reset with results pending and samples in flight
        out_ready = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            drive(i, 0, 1'b1, 1'b1);
            tick;
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_sum", $signed(out_sum), 0);
        tick;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) tick;
        chk("rst_discard", out_valid, 0);
        drive(-3, 0, 1'b1, 1'b1);
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        chk("after_rst_valid", out_valid, 1);
        chk("after_rst_sum", $signed(out_sum), -48);
        tick;

        // narrow accumulator wrap and overflow flag
        valid10 = 1'b1; p10 = lanes(31); shift10 = '0; first10 = 1'b1; last10 = 1'b0;
        tick;
        first10 = 1'b0; last10 = 1'b1;
        tick;
        valid10 = 1'b0;
        tick;
        chk("wrap_no_early", out_valid10, 0);
        tick;
        chk("wrap_valid", out_valid10, 1);
        chk("wrap_sum", $signed(out_sum10), -32);
        chk("wrap_ovf", out_ovf10, 1);
        tick;
        valid10 = 1'b1; p10 = lanes(1); first10 = 1'b1; last10 = 1'b1;
        tick;
        valid10 = 1'b0;
        tick;
        tick;
        chk("wrap_next_sum", $signed(out_sum10), 16);
        chk("wrap_next_ovf", out_ovf10, 0);
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pe_acc_tree.md
PE_ACC_TREE -- requirements
Module: pe_acc_tree

Interface
REQ-001 SHALL provide parameter N_IN, default 16: number of signed partial products; a multiple of GROUP.
REQ-002 SHALL provide parameter GROUP, default 4: inputs per first-level group; N_IN/GROUP is a power of two.
REQ-003 SHALL provide parameter IN_W, default 6: width of each signed partial product.
REQ-004 SHALL provide parameter SHIFT_W, default 3: width of the per-sample left-shift amount.
REQ-005 SHALL provide parameter ACC_W, default 24: accumulator and result width.
REQ-006 SHALL have port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port in_valid, input, 1: in_p, in_shift, in_first and in_last are valid this cycle.
REQ-009 SHALL have port in_ready, output, 1: the block accepts the sample this cycle.
REQ-010 SHALL have port in_p, input, N_IN*IN_W: packed signed products; lane k occupies bits [k*IN_W +: IN_W].
REQ-011 SHALL have port in_shift, input, SHIFT_W: left-shift applied to this sample's tree sum (bit-significance weight).
REQ-012 SHALL have port in_first, input, 1: this sample starts a new accumulation.
REQ-013 SHALL have port in_last, input, 1: this sample ends the accumulation and produces a result.
REQ-014 SHALL have port out_valid, output, 1: out_sum and out_ovf hold a result.
REQ-015 SHALL have port out_ready, input, 1: the consumer takes the result this cycle.
REQ-016 SHALL have port out_sum, output, ACC_W: signed accumulated result.
REQ-017 SHALL have port out_ovf, output, 1: signed overflow occurred somewhere in this result's accumulation.

Function
REQ-018 SHALL accept a sample when in_valid && in_ready.
REQ-019 SHALL define stall = out_valid && !out_ready, and SHALL drive in_ready = !stall.
REQ-020 SHALL run three register stages, each holding a valid bit plus payload, all frozen while stall is high:
- S1: N_IN/GROUP group sums, each sign-extended to IN_W+clog2(GROUP) bits.
- S2: total tree sum, width TW = IN_W+clog2(N_IN) bits, exact with no overflow possible.
- S3: accumulator.
REQ-021 SHALL compute the S3 update as acc_next = (first ? 0 : acc) + sext_ACC_W(S2 << shift), with two's-complement wrap modulo 2^ACC_W.
REQ-022 SHALL set the overflow flag when an S3 addition overflows signed; the flag is cleared by first and is sticky until the result is taken.
REQ-023 SHALL raise out_valid on the clock edge at which the sample carrying last updates S3; latency from acceptance of that sample to out_valid high is 3 cycles.
REQ-024 SHALL hold out_valid, out_sum and out_ovf stable until out_valid && out_ready.
REQ-025 SHALL support first && last on the same sample as a single-sample result.
REQ-026 SHALL, for a sample without first that follows an emitted result, continue accumulating from the emitted value.
REQ-027 SHALL, when a result handshake and a new sample reaching S3 occur in the same cycle, accept both with no bubble.
REQ-028 SHALL leave S3 unchanged by cycles in which no valid sample reaches S3.

Reset
REQ-029 SHALL, while rst_n is low, asynchronously clear all valid bits, the accumulator, the overflow flag, out_valid, out_sum and out_ovf to 0.
REQ-030 SHALL discard any in-flight samples and partial accumulation when reset asserts mid-operation.
REQ-031 SHALL present in_ready high in the first cycle after reset deasserts.

Structure
REQ-032 SHALL place the default parameter values and a clog2 constant function in the shared package pe_pkg.
REQ-033 SHALL instantiate the combinational sub-module pe_add_group (GROUP signed inputs in, one sign-extended sum out) N_IN/GROUP times to feed S1.

Verification
REQ-034 SHALL pass, with defaults: all lanes = 6'h3F, shift 0, first=last=1 -> out_sum = -16 three cycles later, out_ovf = 0.
REQ-035 SHALL pass: lanes = +9, 4 samples with shifts 0,1,2,3, first on sample 1 and last on sample 4 -> out_sum = 144*15 = 2160.
REQ-036 SHALL pass: out_ready held low for 5 cycles with results pending -> in_ready low, out_sum stable, no sample lost; all results delivered in order once out_ready returns high.
REQ-037 SHALL pass, with ACC_W=10: two samples of all lanes = +31, shift 0 -> wrapped sum -32 with out_ovf = 1.
REQ-038 SHALL pass: rst_n pulsed low while two samples are in flight -> out_valid = 0 immediately; the next first/last sample produces its exact sum.
REQ-039 SHALL pass: back-to-back first/last samples with out_ready tied high -> one result per cycle, zero bubbles.
